// File: rtl/fft64_sdf_ctrl.sv
// rtl/fft64_sdf_ctrl.sv - sequencer for the radix-2 SDF 64-point FFT pipeline
//
// Counts frame samples, gates the advance of every stage register, drives the
// per-stage butterfly/pass select and twiddle ROM index, pads in-frame gaps
// with zeros, flushes the pipe after the last frame and tags the outputs.
//
// Optional feature macro: FFT_BITREV_IDX_EN
//   defined   : out_idx is the bit-reversed stage-6 count (natural bin number)
//   undefined : out_idx is the stage-6 count (pipeline emission order)
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   in_valid   input sample valid this cycle
//   pipe_en    advance enable for all stage shift/butterfly registers
//   din_zero   datapath substitutes zero for the input sample
//   bf_sel     per stage: 1 = butterfly mode, 0 = fill/drain delay line
//   tw_addr    twiddle ROM index, N_LOG2-1 bits per stage 0..N_LOG2-2
//   out_valid  last stage output valid
//   out_last   out_valid on the 64th output of a frame
//   out_idx    index of the current output sample
//   frame_err  one-cycle pulse when in_valid drops mid-frame
//   busy       frame in progress or pipe not yet drained

module fft64_sdf_ctrl #(
  parameter int N_LOG2    = 6,
  parameter int STAGE_LAT = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               pipe_en,
  output logic                               din_zero,
  output logic [N_LOG2-1:0]                  bf_sel,
  output logic [(N_LOG2-1)*(N_LOG2-1)-1:0]   tw_addr,
  output logic                               out_valid,
  output logic                               out_last,
  output logic [N_LOG2-1:0]                  out_idx,
  output logic                               frame_err,
  output logic                               busy
);

  localparam int N         = 1 << N_LOG2;
  localparam int TOTAL_LAT = N - 1 + N_LOG2 * STAGE_LAT;
  localparam int FW        = $clog2(TOTAL_LAT + 1);
  localparam int TW        = N_LOG2 - 1;
  localparam logic [N_LOG2-1:0] CNT_ONE   = 1;
  localparam logic [FW-1:0]     FLUSH_ONE = 1;
  localparam logic [FW-1:0]     FLUSH_LD  = FW'(TOTAL_LAT);

  // Ticks from the input to the output of stage k-1: sum of D_s + STAGE_LAT.
  function automatic int tap_pos(input int k);
    return (N - (N >> k)) + k * STAGE_LAT;
  endfunction

  logic                 iv;
  logic [N_LOG2-1:0]    cnt [N_LOG2+1];   // cnt[0] doubles as the input counter
  logic                 gap_active;
  logic [FW-1:0]        flush_cnt;
  logic [TOTAL_LAT-1:0] sr;               // one valid chain, tapped per stage
  logic [N_LOG2:0]      sv;
  logic                 mid_frame;
  logic                 gap_fill;
  logic                 frame_end;
  logic                 flushing;

  // Gating in_valid with rst_n keeps every combinational output at zero
  // while reset is held, even if the source keeps asserting in_valid.
  assign iv        = in_valid & rst_n;
  assign mid_frame = (cnt[0] != '0);
  assign flushing  = (flush_cnt != '0);
  // Once a gap opens, the rest of the frame is zero-filled regardless of
  // in_valid; a returning in_valid is not a new frame.
  assign gap_fill  = gap_active | (mid_frame & ~iv);
  assign frame_err = mid_frame & ~iv & ~gap_active;
  assign din_zero  = gap_fill;
  assign pipe_en   = iv | gap_fill | flushing;
  assign busy      = mid_frame | gap_fill | flushing;
  assign sv[0]     = iv | gap_fill;
  assign frame_end = sv[0] & (cnt[0] == '1);

  for (genvar k = 1; k <= N_LOG2; k++) begin : g_tap
    localparam int P = tap_pos(k);
    assign sv[k] = sr[P-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr         <= '0;
      gap_active <= 1'b0;
      flush_cnt  <= '0;
      for (int s = 0; s <= N_LOG2; s++) cnt[s] <= '0;
    end else if (pipe_en) begin
      sr <= {sr[TOTAL_LAT-2:0], sv[0]};
      for (int s = 0; s <= N_LOG2; s++) begin
        if (sv[s]) cnt[s] <= cnt[s] + CNT_ONE;
      end
      if (frame_end)      gap_active <= 1'b0;
      else if (frame_err) gap_active <= 1'b1;
      // Each frame end restarts the drain window, so back-to-back frames
      // keep the pipe running until the last one has fully emerged.
      if (frame_end)      flush_cnt <= FLUSH_LD;
      else if (flushing)  flush_cnt <= flush_cnt - FLUSH_ONE;
    end
  end

  for (genvar s = 0; s < N_LOG2; s++) begin : g_bf
    assign bf_sel[s] = cnt[s][N_LOG2-1-s];
  end

  for (genvar s = 0; s < TW; s++) begin : g_tw
    logic [TW-1:0] lo;
    assign lo = cnt[s][TW-1:0];
    // Shifting the full low field and truncating wraps mod 2^TW.
    assign tw_addr[TW*s +: TW] = bf_sel[s] ? '0 : TW'(lo << s);
  end

  assign out_valid = sv[N_LOG2] & pipe_en;
  assign out_last  = out_valid & (cnt[N_LOG2] == '1);

`ifdef FFT_BITREV_IDX_EN
  for (genvar i = 0; i < N_LOG2; i++) begin : g_rev
    assign out_idx[i] = cnt[N_LOG2][N_LOG2-1-i];
  end
`else
  assign out_idx = cnt[N_LOG2];
`endif

endmodule

// File: tb/tb_fft64_sdf_ctrl.sv
// tb/tb_fft64_sdf_ctrl.sv - directed self-checking bench for fft64_sdf_ctrl

module tb_fft64_sdf_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        pipe_en;
  logic        din_zero;
  logic [5:0]  bf_sel;
  logic [24:0] tw_addr;
  logic        out_valid;
  logic        out_last;
  logic [5:0]  out_idx;
  logic        frame_err;
  logic        busy;

  int n_vec;
  int n_err;

  fft64_sdf_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .pipe_en   (pipe_en),
    .din_zero  (din_zero),
    .bf_sel    (bf_sel),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_idx   (out_idx),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] exp_idx(input int raw);
    logic [5:0] r;
    logic [5:0] o;
    r = 6'(raw);
`ifdef FFT_BITREV_IDX_EN
    for (int i = 0; i < 6; i++) o[i] = r[5-i];
`else
    o = r;
`endif
    return o;
  endfunction

  // One cycle: drive in_valid after the falling edge, sample settled outputs.
  task automatic drive(input logic v);
    @(negedge clk);
    in_valid = v;
    #1;
  endtask

  // nfr contiguous frames starting at tick 0; optional gap in the first frame.
  task automatic run_case(input string name, input int nfr, input int gap_at, input int gap_len);
    int last_tick;
    int n_in;
    int n_out;
    int raw;
    int c1;
    logic v;
    logic gap;
    logic [5:0] tt;
    logic [4:0] e_tw0;
    logic [4:0] e_tw1;
    n_in      = 64 * nfr;
    last_tick = n_in - 1 + 69;
    gap       = (gap_at >= 0);
    n_out     = 0;
    for (int t = 0; t <= last_tick + 6; t++) begin
      v = (t < n_in) && !(gap && t >= gap_at && t < gap_at + gap_len);
      drive(v);
      check({name, ".pipe_en"},   32'(pipe_en),   32'(t <= last_tick));
      check({name, ".busy"},      32'(busy),      32'(t >= 1 && t <= last_tick));
      check({name, ".frame_err"}, 32'(frame_err), 32'(gap && t == gap_at));
      check({name, ".din_zero"},  32'(din_zero),  32'(gap && t >= gap_at && t <= 63));
      check({name, ".out_valid"}, 32'(out_valid), 32'(t >= 69 && t <= last_tick));
      if (t >= 69 && t <= last_tick) begin
        raw = (t - 69) % 64;
        check({name, ".out_idx"},  32'(out_idx),  32'(exp_idx(raw)));
        check({name, ".out_last"}, 32'(out_last), 32'(raw == 63));
      end else begin
        check({name, ".out_last"}, 32'(out_last), 32'(0));
      end
      if (out_valid) n_out++;
      if (t < n_in) begin
        tt    = 6'(t);
        e_tw0 = tt[5] ? 5'd0 : tt[4:0];
        check({name, ".bf_sel0"}, 32'(bf_sel[0]),    32'(tt[5]));
        check({name, ".tw0"},     32'(tw_addr[4:0]), 32'(e_tw0));
      end
      if (t >= 33 && t < n_in + 33) begin
        c1    = (t - 33) % 64;
        tt    = 6'(c1);
        e_tw1 = tt[4] ? 5'd0 : {tt[3:0], 1'b0};
        check({name, ".bf_sel1"}, 32'(bf_sel[1]),    32'(tt[4]));
        check({name, ".tw1"},     32'(tw_addr[9:5]), 32'(e_tw1));
      end
    end
    check({name, ".n_out"}, 32'(n_out), 32'(64 * nfr));
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst.pipe_en",   32'(pipe_en),   32'(0));
    check("rst.busy",      32'(busy),      32'(0));
    check("rst.out_valid", 32'(out_valid), 32'(0));
    check("rst.bf_sel",    32'(bf_sel),    32'(0));
    check("rst.tw_addr",   32'(tw_addr),   32'(0));
    check("rst.out_idx",   32'(out_idx),   32'(0));
    check("rst.din_zero",  32'(din_zero),  32'(0));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) drive(1'b0);

    run_case("single", 1, -1, 0);
    run_case("b2b",    3, -1, 0);
    run_case("gap",    1, 20, 5);

    // Abort a frame with reset once in_cnt has reached 40.
    for (int t = 0; t < 40; t++) drive(1'b1);
    check("pre_rst.bf_sel0", 32'(bf_sel[0]), 32'(1));
    check("pre_rst.busy",    32'(busy),      32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst.pipe_en",  32'(pipe_en),  32'(0));
    check("mid_rst.busy",     32'(busy),     32'(0));
    check("mid_rst.bf_sel",   32'(bf_sel),   32'(0));
    check("mid_rst.tw_addr",  32'(tw_addr),  32'(0));
    check("mid_rst.out_valid",32'(out_valid),32'(0));
    check("mid_rst.din_zero", 32'(din_zero), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    repeat (3) begin
      drive(1'b0);
      check("post_rst.busy",      32'(busy),      32'(0));
      check("post_rst.out_valid", 32'(out_valid), 32'(0));
    end
    run_case("after_rst", 1, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
